// File: rtl/bcd_stopwatch_core_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_pkg
//  Description : Shared BCD limits, run-state encoding and nibble clamp helper
//                for the BCD stopwatch core.
//  Revision    : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_MIN = 4'd0;

    typedef enum logic [0:0] {
        RUN_STOPPED = 1'b0,
        RUN_ACTIVE  = 1'b1
    } run_state_t;

    function automatic logic [3:0] bcd_clamp(input logic [3:0] nibble);
        return (nibble > BCD_MAX) ? BCD_MAX : nibble;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_stopwatch_core_if.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_stopwatch_core_if
//  Description : Control, preset and display bus of the BCD stopwatch core.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bcd_stopwatch_core_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      tick_en;
    logic                      start_stop_btn;
    logic                      lap_btn;
    logic                      clear;
    logic                      decrement;
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   load_value;
    logic [4*NUM_DIGITS-1:0]   digits;
    logic [4*NUM_DIGITS-1:0]   lap_digits;
    logic                      running;
    logic                      done;

    modport master (
        output tick_en, start_stop_btn, lap_btn, clear, decrement, load, load_value,
        input  digits, lap_digits, running, done
    );

    modport slave (
        input  tick_en, start_stop_btn, lap_btn, clear, decrement, load, load_value,
        output digits, lap_digits, running, done
    );
endinterface
`default_nettype wire

// File: rtl/bcd_stopwatch_core_digit_cell.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit_cell
//  Description : One BCD digit register with load, up/down step and ripple
//                carry/borrow terms for the next-higher digit.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_cell
    import stopwatch_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       dir,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       carry_in,
    input  logic       borrow_in,
    output logic [3:0] digit,
    output logic       carry_out,
    output logic       borrow_out
);

    logic [3:0] r_digit;

    // carry_in/borrow_in already encode "all lower digits at 9/0"
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_digit <= BCD_MIN;
        end else if (load) begin
            r_digit <= load_val;
        end else if (en) begin
            if (dir) begin
                if (borrow_in) begin
                    r_digit <= (r_digit == BCD_MIN) ? BCD_MAX : r_digit - 4'd1;
                end
            end else if (carry_in) begin
                r_digit <= (r_digit == BCD_MAX) ? BCD_MIN : r_digit + 4'd1;
            end
        end
    end

    assign digit      = r_digit;
    assign carry_out  = carry_in  & (r_digit == BCD_MAX);
    assign borrow_out = borrow_in & (r_digit == BCD_MIN);

endmodule
`default_nettype wire

// File: rtl/bcd_stopwatch_core.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_stopwatch_core
//  Description : N-digit BCD up/down stopwatch with tick enable, lap capture,
//                wrap or saturate-and-stop limit handling and terminal pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter bit WRAP       = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    bcd_stopwatch_core_if.slave   bus
);

    localparam int c_W = 4 * NUM_DIGITS;

    logic             r_start_prev;
    logic             r_lap_prev;
    run_state_t       r_run;
    run_state_t       w_run_next;
    logic             r_done;
    logic             w_done_next;
    logic [c_W-1:0]   r_lap;

    logic             w_start_edge;
    logic             w_lap_edge;
    logic             w_step;
    logic             w_at_limit;
    logic             w_cell_en;
    logic             w_cell_load;
    logic [c_W-1:0]   w_load_nib;
    logic [c_W-1:0]   w_digits;
    logic [NUM_DIGITS:0] w_carry;
    logic [NUM_DIGITS:0] w_borrow;

    assign w_start_edge = bus.start_stop_btn & ~r_start_prev;
    assign w_lap_edge   = bus.lap_btn & ~r_lap_prev;
    assign w_step       = (r_run == RUN_ACTIVE) & bus.tick_en & ~bus.clear & ~bus.load;

    // The chain tails are 1 only when every digit sits at the limit
    assign w_at_limit   = bus.decrement ? w_borrow[NUM_DIGITS] : w_carry[NUM_DIGITS];
    assign w_cell_en    = w_step & (WRAP | ~w_at_limit);
    assign w_cell_load  = bus.clear | bus.load;

    assign w_carry[0]   = 1'b1;
    assign w_borrow[0]  = 1'b1;

    generate
        for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
            assign w_load_nib[i*4 +: 4] = bus.clear
                ? (bus.decrement ? BCD_MAX : BCD_MIN)
                : bcd_clamp(bus.load_value[i*4 +: 4]);

            bcd_digit_cell u_cell (
                .clk        (clk),
                .reset      (reset),
                .en         (w_cell_en),
                .dir        (bus.decrement),
                .load       (w_cell_load),
                .load_val   (w_load_nib[i*4 +: 4]),
                .carry_in   (w_carry[i]),
                .borrow_in  (w_borrow[i]),
                .digit      (w_digits[i*4 +: 4]),
                .carry_out  (w_carry[i+1]),
                .borrow_out (w_borrow[i+1])
            );
        end
    endgenerate

    always_comb begin
        w_run_next  = r_run;
        w_done_next = w_step & w_at_limit;
        if (bus.clear) begin
            w_run_next = RUN_STOPPED;
        end else begin
            if (w_start_edge) begin
                w_run_next = (r_run == RUN_ACTIVE) ? RUN_STOPPED : RUN_ACTIVE;
            end
            if (!WRAP && w_step && w_at_limit) begin
                w_run_next = RUN_STOPPED;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_start_prev <= 1'b0;
            r_lap_prev   <= 1'b0;
            r_run        <= RUN_STOPPED;
            r_done       <= 1'b0;
            r_lap        <= '0;
        end else begin
            r_start_prev <= bus.start_stop_btn;
            r_lap_prev   <= bus.lap_btn;
            r_run        <= w_run_next;
            r_done       <= w_done_next;
            if (bus.clear) begin
                r_lap <= '0;
            end else if (w_lap_edge) begin
                r_lap <= w_digits;
            end
        end
    end

    assign bus.digits     = w_digits;
    assign bus.lap_digits = r_lap;
    assign bus.running    = (r_run == RUN_ACTIVE);
    assign bus.done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_bcd_stopwatch_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_stopwatch_core
//  Description : Directed plus random test of the stopwatch core, saturate
//                (WRAP=0) and wrap (WRAP=1) instances side by side.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_stopwatch_core;

    localparam int MAXV = 9999;

    logic        clk;
    logic        reset;
    logic        tick_en, start_stop_btn, lap_btn, clear, decrement, load;
    logic [15:0] load_value;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: counts as plain integers, index = WRAP value
    int m_cnt [2];
    int m_lap [2];
    bit m_run [2];
    bit m_done[2];
    bit prev_ss, prev_lap;

    bcd_stopwatch_core_if #(.NUM_DIGITS(4)) if0 ();
    bcd_stopwatch_core_if #(.NUM_DIGITS(4)) if1 ();

    assign if0.tick_en = tick_en;        assign if1.tick_en = tick_en;
    assign if0.start_stop_btn = start_stop_btn; assign if1.start_stop_btn = start_stop_btn;
    assign if0.lap_btn = lap_btn;        assign if1.lap_btn = lap_btn;
    assign if0.clear = clear;            assign if1.clear = clear;
    assign if0.decrement = decrement;    assign if1.decrement = decrement;
    assign if0.load = load;              assign if1.load = load;
    assign if0.load_value = load_value;  assign if1.load_value = load_value;

    bcd_stopwatch_core #(.NUM_DIGITS(4), .WRAP(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(if0));
    bcd_stopwatch_core #(.NUM_DIGITS(4), .WRAP(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int place;
        r = '0;
        place = 1;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = 4'((v / place) % 10);
            place = place * 10;
        end
        return r;
    endfunction

    function automatic int bcd_value(input logic [15:0] x);
        int v, place, nib;
        v = 0;
        place = 1;
        for (int i = 0; i < 4; i++) begin
            nib = int'(x[i*4 +: 4]);
            if (nib > 9) nib = 9;
            v = v + nib * place;
            place = place * 10;
        end
        return v;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int w = 0; w < 2; w++) begin
            m_cnt[w] = 0; m_lap[w] = 0; m_run[w] = 0; m_done[w] = 0;
        end
        prev_ss = 0;
        prev_lap = 0;
    endtask

    task automatic model_update();
        bit se, le, stepping, at_lim;
        se = start_stop_btn && !prev_ss;
        le = lap_btn && !prev_lap;
        prev_ss = start_stop_btn;
        prev_lap = lap_btn;
        for (int w = 0; w < 2; w++) begin
            m_done[w] = 0;
            if (clear) begin
                m_cnt[w] = decrement ? MAXV : 0;
                m_lap[w] = 0;
                m_run[w] = 0;
            end else begin
                stepping = m_run[w] && tick_en && !load;
                if (le) m_lap[w] = m_cnt[w];
                if (se) m_run[w] = !m_run[w];
                if (load) begin
                    m_cnt[w] = bcd_value(load_value);
                end else if (stepping) begin
                    at_lim = decrement ? (m_cnt[w] == 0) : (m_cnt[w] == MAXV);
                    if (!at_lim) begin
                        m_cnt[w] = m_cnt[w] + (decrement ? -1 : 1);
                    end else begin
                        m_done[w] = 1;
                        if (w == 1) m_cnt[w] = decrement ? MAXV : 0;
                        else        m_run[w] = 0;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        chk ("w0.digits",  if0.digits,     to_bcd(m_cnt[0]));
        chk ("w0.lap",     if0.lap_digits, to_bcd(m_lap[0]));
        chk1("w0.running", if0.running,    m_run[0]);
        chk1("w0.done",    if0.done,       m_done[0]);
        chk ("w1.digits",  if1.digits,     to_bcd(m_cnt[1]));
        chk ("w1.lap",     if1.lap_digits, to_bcd(m_lap[1]));
        chk1("w1.running", if1.running,    m_run[1]);
        chk1("w1.done",    if1.done,       m_done[1]);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        #1;
        check_all();
    endtask

    initial begin
        reset = 1'b1;
        tick_en = 0; start_stop_btn = 0; lap_btn = 0; clear = 0; decrement = 0; load = 0;
        load_value = '0;
        model_reset();
        #12 reset = 1'b0;
        check_all();

        // 1: start, 12 ticks up
        start_stop_btn = 1; cycle();
        start_stop_btn = 0; tick_en = 1;
        repeat (12) cycle();
        tick_en = 0; cycle();
        chk ("t1.digits", if0.digits, 16'h0012);
        chk1("t1.running", if0.running, 1'b1);
        chk1("t1.done", if0.done, 1'b0);

        // 2: full ripple carry, then clamped load
        load = 1; load_value = 16'h0999; cycle();
        load = 0; tick_en = 1; cycle();
        tick_en = 0;
        chk("t2.ripple", if0.digits, 16'h1000);
        load = 1; load_value = 16'hABCD; cycle();
        load = 0;
        chk("t2.clamp", if0.digits, 16'h9999);

        // 3: saturating countdown
        load = 1; load_value = 16'h0001; decrement = 1; cycle();
        load = 0; tick_en = 1; cycle();
        chk ("t3.zero", if0.digits, 16'h0000);
        chk1("t3.nodone", if0.done, 1'b0);
        cycle();
        chk1("t3.done", if0.done, 1'b1);
        chk1("t3.stopped", if0.running, 1'b0);
        chk ("t3.hold", if0.digits, 16'h0000);
        cycle();
        chk ("t3.hold2", if0.digits, 16'h0000);
        chk1("t3.done_off", if0.done, 1'b0);
        tick_en = 0;

        // 4: wrap up 9999 -> 0000
        decrement = 0; load = 1; load_value = 16'h9999; cycle();
        load = 0; tick_en = 1; cycle();
        tick_en = 0;
        chk ("t4.wrap", if1.digits, 16'h0000);
        chk1("t4.done", if1.done, 1'b1);
        chk1("t4.run", if1.running, 1'b1);
        cycle();
        chk1("t4.done_off", if1.done, 1'b0);

        // 5: lap + tick, start + tick while stopped
        load = 1; load_value = 16'h0042; cycle();
        load = 0; lap_btn = 1; tick_en = 1; cycle();
        chk("t5.lap", if1.lap_digits, 16'h0042);
        chk("t5.step", if1.digits, 16'h0043);
        lap_btn = 0; start_stop_btn = 1; cycle();
        chk ("t5.nostep", if0.digits, 16'h0042);
        chk1("t5.run", if0.running, 1'b1);
        start_stop_btn = 0; cycle(); cycle();

        // 6: clear while running, then async reset mid-count
        clear = 1; decrement = 1; cycle();
        clear = 0; tick_en = 0;
        chk ("t6.clear", if0.digits, 16'h9999);
        chk1("t6.stop", if0.running, 1'b0);
        chk ("t6.lap", if0.lap_digits, 16'h0000);
        start_stop_btn = 1; cycle();
        start_stop_btn = 0; tick_en = 1; cycle(); cycle(); cycle();
        #3 reset = 1'b1;
        model_reset();
        #1;
        chk ("t6.rst_digits", if0.digits, 16'h0000);
        chk1("t6.rst_run", if0.running, 1'b0);
        check_all();
        @(posedge clk); #1;
        check_all();
        #2 reset = 1'b0;
        tick_en = 1; cycle();
        chk("t6.no_resume", if0.digits, 16'h0000);

        // Random phase
        for (int n = 0; n < 600; n++) begin
            tick_en = 1'($urandom_range(0, 1));
            start_stop_btn = ($urandom_range(0, 5) == 0);
            lap_btn = ($urandom_range(0, 3) == 0);
            clear = ($urandom_range(0, 40) == 0);
            load = ($urandom_range(0, 12) == 0);
            case ($urandom_range(0, 3))
                0: load_value = 16'h9998;
                1: load_value = 16'h0001;
                default: load_value = 16'($urandom);
            endcase
            if ($urandom_range(0, 15) == 0) decrement = ~decrement;
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
